// File: rtl/handshake_pipe_full_patting.sv
// Two-entry registered handshake pipeline (output register plus skid register).
// Every output comes straight from a flop, so no input reaches an output combinationally.
module handshake_pipe_full_patting #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              master_valid,
    input  logic [DATA_W-1:0] master_data,
    output logic              master_ready,
    output logic              slave_valid,
    output logic [DATA_W-1:0] slave_data,
    input  logic              slave_ready,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              in_hs, out_hs;

    assign in_hs  = master_valid & ready_q;
    assign out_hs = valid_q & slave_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    out_d   = master_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_hs && !out_hs) begin
                    skid_d  = master_data;
                    state_d = FULL;
                end else if (in_hs && out_hs) begin
                    out_d   = master_data;
                end else if (out_hs) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // ready is low here, so only the drain side can move
                if (out_hs) begin
                    out_d   = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        ready_d = (state_d != FULL);
        valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            EMPTY:   occupancy = 2'd0;
            BUSY:    occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign master_ready = ready_q;
    assign slave_valid  = valid_q;
    assign slave_data   = out_q;

endmodule

// File: tb/tb_handshake_pipe_full_patting.sv
// Scoreboard bench: a queue of accepted-but-undelivered beats predicts every output,
// while directed scenarios and a random phase drive the handshakes.
module tb_handshake_pipe_full_patting;

    logic        clk;
    logic        rst_n;
    logic        masterValid;
    logic [31:0] masterData;
    logic        masterReady;
    logic        slaveValid;
    logic [31:0] slaveData;
    logic        slaveReady;
    logic [1:0]  occupancy;

    int          chk;
    int          err;
    bit          monOn;
    logic [31:0] expQ[$];

    handshake_pipe_full_patting #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .master_valid (masterValid),
        .master_data  (masterData),
        .master_ready (masterReady),
        .slave_valid  (slaveValid),
        .slave_data   (slaveData),
        .slave_ready  (slaveReady),
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // The pipe holds exactly the accepted-but-undelivered beats, oldest at the head.
    always @(negedge clk) begin
        if (monOn) begin
            checkOutput("occupancy", 32'(occupancy), 32'(expQ.size()));
            checkOutput("slave_valid", 32'(slaveValid), 32'(expQ.size() > 0));
            checkOutput("master_ready", 32'(masterReady), 32'(expQ.size() < 2));
            if (expQ.size() > 0) begin
                checkOutput("slave_data", slaveData, expQ[0]);
                if (slaveValid && slaveReady) void'(expQ.pop_front());
            end
            if (masterValid && masterReady) expQ.push_back(masterData);
        end
    end

    task automatic applyStimulus(input logic [31:0] d);
        bit acc;
        acc = 1'b0;
        masterValid = 1'b1;
        masterData  = d;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = masterReady;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            chk++;
            err++;
            $display("[TB] FAIL accept_timeout: beat 0x%08h not accepted, expected acceptance", d);
        end
        masterValid = 1'b0;
        masterData  = $urandom;
    endtask

    task automatic drain();
        slaveReady = 1'b1;
        for (int n = 0; n < 100 && expQ.size() > 0; n++) @(posedge clk);
        #1;
        chk++;
        if (expQ.size() != 0) begin
            err++;
            $display("[TB] FAIL drain_timeout: %0d beats left, expected 0", expQ.size());
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #3;
        monOn       = 1'b0;
        rst_n       = 1'b0;
        masterValid = 1'b0;
        #1;
        checkOutput("rst_slave_valid", 32'(slaveValid), 32'd0);
        checkOutput("rst_slave_data", slaveData, 32'd0);
        checkOutput("rst_master_ready", 32'(masterReady), 32'd0);
        checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
        expQ.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("ready_before_edge", 32'(masterReady), 32'd0);
        @(posedge clk);
        monOn = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", chk, err + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        chk         = 0;
        err         = 0;
        monOn       = 1'b0;
        rst_n       = 1'b0;
        masterValid = 1'b0;
        masterData  = 32'h0;
        slaveReady  = 1'b0;
        doReset();

        // single beat from EMPTY, visible one cycle later
        applyStimulus(32'hA5A5_0001);
        @(negedge clk);
        checkOutput("single_valid", 32'(slaveValid), 32'd1);
        checkOutput("single_data", slaveData, 32'hA5A5_0001);
        @(posedge clk);
        #1;
        drain();

        // streaming with the sink always ready
        slaveReady = 1'b1;
        for (int i = 1; i <= 16; i++) applyStimulus(32'(i));
        drain();

        // backpressure: third beat must wait until the sink opens
        slaveReady = 1'b0;
        applyStimulus(32'h11);
        applyStimulus(32'h22);
        masterValid = 1'b1;
        masterData  = 32'h33;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_full_occ", 32'(occupancy), 32'd2);
            checkOutput("bp_full_ready", 32'(masterReady), 32'd0);
            @(posedge clk);
            #1;
        end
        slaveReady = 1'b1;
        applyStimulus(32'h33);
        drain();

        // simultaneous accept and deliver while BUSY
        slaveReady = 1'b0;
        applyStimulus(32'h44);
        slaveReady = 1'b1;
        applyStimulus(32'h55);
        @(negedge clk);
        checkOutput("simul_occ", 32'(occupancy), 32'd1);
        checkOutput("simul_data", slaveData, 32'h55);
        @(posedge clk);
        #1;
        drain();

        // reset while FULL discards both held beats
        slaveReady = 1'b0;
        applyStimulus(32'h66);
        applyStimulus(32'h77);
        @(negedge clk);
        checkOutput("pre_reset_occ", 32'(occupancy), 32'd2);
        doReset();
        slaveReady = 1'b1;
        applyStimulus(32'h88);
        drain();

        // random traffic on both sides
        for (int c = 0; c < 400; c++) begin
            masterValid = ($urandom_range(0, 2) != 0);
            masterData  = $urandom;
            slaveReady  = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        masterValid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule

// File: doc/handshake_pipe_full_patting.md
HANDSHAKE_PIPE_FULL_PATTING -- requirements
Module: handshake_pipe_full_patting

Interface
REQ-001 SHALL have parameter: DATA_W, default 32, payload width in bits.
REQ-002 SHALL have port: clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: master_valid  input  1  upstream beat present.
REQ-005 SHALL have port: master_data  input  DATA_W  upstream payload.
REQ-006 SHALL have port: master_ready  output  1  block can accept a beat, registered.
REQ-007 SHALL have port: slave_valid  output  1  downstream beat present, registered.
REQ-008 SHALL have port: slave_data  output  DATA_W  downstream payload, registered.
REQ-009 SHALL have port: slave_ready  input  1  downstream accepts beat.
REQ-010 SHALL have port: occupancy  output  2  number of beats held, 0..2.

Function
REQ-011 SHALL register valid, data and ready paths; no combinational path from any input to any output.
REQ-012 SHALL hold a beat in two storage entries: output register (out_reg) driving slave_data, skid register (skid_reg).
REQ-013 SHALL define handshakes: in_hs = master_valid & master_ready; out_hs = slave_valid & slave_ready.
REQ-014 SHALL implement FSM states EMPTY (0 beats), BUSY (out_reg valid), FULL (out_reg and skid_reg valid).
REQ-015 SHALL, in EMPTY, on in_hs load out_reg with master_data and go to BUSY; otherwise stay.
REQ-016 SHALL, in BUSY, on in_hs & ~out_hs load skid_reg with master_data and go to FULL.
REQ-017 SHALL, in BUSY, on in_hs & out_hs load out_reg with master_data and stay in BUSY.
REQ-018 SHALL, in BUSY, on ~in_hs & out_hs go to EMPTY; with neither handshake stay.
REQ-019 SHALL, in FULL, on out_hs copy skid_reg to out_reg and go to BUSY; otherwise stay; no in_hs is possible in FULL.
REQ-020 SHALL drive slave_valid = 1 in BUSY and FULL, 0 in EMPTY.
REQ-021 SHALL drive master_ready = 1 in EMPTY and BUSY, 0 in FULL, registered from next state.
REQ-022 SHALL drive occupancy = 0, 1, 2 for EMPTY, BUSY, FULL.
REQ-023 SHALL present an accepted beat on slave_valid/slave_data exactly 1 cycle after in_hs when the block was EMPTY.
REQ-024 SHALL sustain one beat per cycle when slave_ready is held high.
REQ-025 SHALL keep slave_valid high and slave_data stable from assertion until out_hs.
REQ-026 SHALL deliver beats in acceptance order, with no loss or duplication.
REQ-027 SHALL ignore master_data when master_valid = 0; storage registers change only as in REQ-015..019.

Reset
REQ-028 SHALL, while rst_n = 0, force state EMPTY, slave_valid = 0, master_ready = 0, occupancy = 0, out_reg = skid_reg = 0.
REQ-029 SHALL assert master_ready on the first rising clk edge after rst_n deasserts.
REQ-030 SHALL discard all held beats when reset is asserted mid-operation, in any state.

Verification
REQ-031 SHALL cover reset: rst_n low -> slave_valid = 0, slave_data = 0, master_ready = 0, occupancy = 0; first edge after release -> master_ready = 1.
REQ-032 SHALL cover single beat: master_valid with 0xA5A50001 accepted at cycle N from EMPTY -> slave_valid = 1, slave_data = 0xA5A50001 at N+1, occupancy = 1.
REQ-033 SHALL cover streaming: slave_ready = 1, beats 0x1..0x10 back-to-back -> 16 outputs on consecutive cycles, latency 1, master_ready constantly 1.
REQ-034 SHALL cover backpressure: slave_ready = 0, offer 0x11, 0x22, 0x33 -> 0x11 and 0x22 accepted, master_ready = 0 and occupancy = 2 after the second; after slave_ready = 1, outputs 0x11, 0x22, 0x33 in order.
REQ-035 SHALL cover simultaneous events: in BUSY holding 0x44, in_hs with 0x55 and out_hs in the same cycle -> state BUSY, slave_data = 0x55 next cycle, 0x44 seen exactly once.
REQ-036 SHALL cover reset mid-operation: in FULL, pulse rst_n low -> occupancy = 0 and slave_valid = 0 immediately; no stale beat after release.
